// File: rtl/bus_block_writer.sv
// rtl/bus_block_writer.sv - bus initiator copying a word stream to consecutive bus addresses
//
// Purpose: second bus master that writes one 16-bit stream word per bus
// transaction (sync/stb/we/wtbt/ack handshake) into consecutive word addresses.
//
// Parameters:
//   TIMEOUT  max STROBE cycles without bus_ack before abort (BUS_TIMEOUT_EN only)
//   CNT_W    width of the word-count input
//
// Optional feature macro: BUS_TIMEOUT_EN (abort a stuck STROBE, set error).
//
// Ports:
//   clk_bus, reset        bus clock, synchronous active-high reset
//   start                 one-cycle block transfer request (ignored while busy)
//   base_addr, count      first byte address (bit 0 ignored), words to write
//   wtbt                  byte enables used for every transfer of the block
//   s_data/s_valid/s_ready  input word stream
//   bus_addr, bus_dout, bus_sync, bus_we, bus_wtbt, bus_stb  registered bus outputs
//   bus_ack               responder acknowledge
//   busy, done, error     status: in progress, end pulse, sticky abort

module bus_block_writer #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 14
) (
  input  logic             clk_bus,
  input  logic             reset,
  input  logic             start,
  input  logic [15:0]      base_addr,
  input  logic [CNT_W-1:0] count,
  input  logic [1:0]       wtbt,
  input  logic [15:0]      s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [15:0]      bus_addr,
  output logic [15:0]      bus_dout,
  output logic             bus_sync,
  output logic             bus_we,
  output logic [1:0]       bus_wtbt,
  output logic             bus_stb,
  input  logic             bus_ack,
  output logic             busy,
  output logic             done,
  output logic             error
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_DATA,
    SETUP,
    STROBE,
    HOLD
  } state_t;

  state_t           state, state_nxt;
  logic [15:0]      addr;
  logic [CNT_W-1:0] rem;
  logic [1:0]       wtbt_r;

  logic load;        // accepted start with nonzero count
  logic zero_done;   // start with count 0: done only
  logic take;        // stream word accepted
  logic advance;     // HOLD: step address and count
  logic finish;      // last word acknowledged
  logic on_bus;      // next state drives the address phase

  // Word addressing only; the low address bit is discarded.
  logic unused_addr_bit;
  assign unused_addr_bit = base_addr[0];

`ifdef BUS_TIMEOUT_EN
  localparam int TCNT_W = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
  logic [TCNT_W-1:0] tcnt;
  logic              abort;
  logic              error_r;
  assign error = error_r;
`else
  // TIMEOUT only matters when the abort logic is built in.
  logic [7:0] unused_timeout;
  assign unused_timeout = 8'(TIMEOUT);
  assign error = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    zero_done = 1'b0;
    take      = 1'b0;
    advance   = 1'b0;
    finish    = 1'b0;
`ifdef BUS_TIMEOUT_EN
    abort     = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          if (count != '0) begin
            load      = 1'b1;
            state_nxt = WAIT_DATA;
          end else begin
            zero_done = 1'b1;
          end
        end
      end
      WAIT_DATA: begin
        if (s_valid) begin
          take      = 1'b1;
          state_nxt = SETUP;
        end
      end
      SETUP: state_nxt = STROBE;
      STROBE: begin
        if (bus_ack) begin
          state_nxt = HOLD;
`ifdef BUS_TIMEOUT_EN
        end else if (tcnt == TCNT_W'(TIMEOUT - 1)) begin
          // This cycle is the TIMEOUT-th without ack.
          abort     = 1'b1;
          state_nxt = IDLE;
`endif
        end
      end
      HOLD: begin
        advance = 1'b1;
        if (rem == CNT_W'(1)) begin
          finish    = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = WAIT_DATA;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign on_bus = (state_nxt == SETUP) || (state_nxt == STROBE) || (state_nxt == HOLD);

  // Outputs are registered from the state being entered, so each state's
  // bus values appear exactly while the FSM sits in it.
  always_ff @(posedge clk_bus) begin
    if (reset) begin
      state    <= IDLE;
      addr     <= '0;
      rem      <= '0;
      wtbt_r   <= '0;
      s_ready  <= 1'b0;
      bus_addr <= '0;
      bus_dout <= '0;
      bus_sync <= 1'b0;
      bus_we   <= 1'b0;
      bus_wtbt <= '0;
      bus_stb  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= finish | zero_done;
      if (load) begin
        addr   <= {base_addr[15:1], 1'b0};
        rem    <= count;
        wtbt_r <= wtbt;
      end
      if (advance) begin
        addr <= addr + 16'd2;   // wraps FFFE -> 0000 naturally
        rem  <= rem - CNT_W'(1);
      end
      if (take) begin
        bus_dout <= s_data;
      end else if (state_nxt == IDLE) begin
        bus_dout <= '0;
      end
      busy     <= (state_nxt != IDLE);
      s_ready  <= (state_nxt == WAIT_DATA);
      bus_sync <= on_bus;
      bus_we   <= on_bus;
      bus_stb  <= (state_nxt == STROBE);
      bus_addr <= on_bus ? addr : 16'd0;
      bus_wtbt <= on_bus ? wtbt_r : 2'b00;
    end
  end

`ifdef BUS_TIMEOUT_EN
  always_ff @(posedge clk_bus) begin
    if (reset) begin
      tcnt    <= '0;
      error_r <= 1'b0;
    end else begin
      if (state != STROBE) begin
        tcnt <= '0;
      end else if (!bus_ack) begin
        tcnt <= tcnt + TCNT_W'(1);
      end
      if (load) begin
        error_r <= 1'b0;
      end else if (abort) begin
        error_r <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_bus_block_writer.sv
// tb/tb_bus_block_writer.sv - directed self-checking bench for bus_block_writer

module tb_bus_block_writer;

  logic        clk_bus = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] base_addr = '0;
  logic [13:0] count = '0;
  logic [1:0]  wtbt = '0;
  logic [15:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] bus_addr, bus_dout;
  logic        bus_sync, bus_we, bus_stb, bus_ack;
  logic [1:0]  bus_wtbt;
  logic        busy, done, error;
  logic        ack_en = 1'b1;

  int n_checks = 0;
  int n_bad = 0;

  always #5 clk_bus = ~clk_bus;

  // Responder acks combinationally from the strobe when enabled.
  assign bus_ack = ack_en & bus_stb;

  bus_block_writer #(.TIMEOUT(8), .CNT_W(14)) dut (
    .clk_bus(clk_bus), .reset(reset), .start(start), .base_addr(base_addr),
    .count(count), .wtbt(wtbt), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .bus_addr(bus_addr), .bus_dout(bus_dout),
    .bus_sync(bus_sync), .bus_we(bus_we), .bus_wtbt(bus_wtbt),
    .bus_stb(bus_stb), .bus_ack(bus_ack), .busy(busy), .done(done),
    .error(error)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Stream source: words with a number of idle cycles before each.
  logic [15:0] q_data[$];
  int          q_gap[$];
  bit          taking = 0;
  bit          gap_loaded = 0;
  int          gap_left = 0;

  initial begin
    forever begin
      @(negedge clk_bus);
      if (taking) begin
        void'(q_data.pop_front());
        void'(q_gap.pop_front());
        gap_loaded = 0;
      end
      if (q_data.size() > 0 && !gap_loaded) begin
        gap_left = q_gap[0];
        gap_loaded = 1;
      end
      if (gap_left > 0) begin
        gap_left--;
        s_valid = 1'b0;
      end else begin
        s_valid = (q_data.size() > 0);
      end
      s_data = s_valid ? q_data[0] : 16'h0;
      taking = s_valid && s_ready;
    end
  end

  // Bus monitor: one record per acknowledged strobe cycle.
  int          cyc = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  logic [15:0] wr_addr[$];
  logic [15:0] wr_data[$];
  logic [1:0]  wr_wtbt[$];
  int          wr_cyc[$];

  initial begin
    forever begin
      @(posedge clk_bus);
      #1;
      cyc++;
      if (bus_stb && bus_ack) begin
        wr_addr.push_back(bus_addr);
        wr_data.push_back(bus_dout);
        wr_wtbt.push_back(bus_wtbt);
        wr_cyc.push_back(cyc);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic clear_log();
    wr_addr.delete(); wr_data.delete(); wr_wtbt.delete(); wr_cyc.delete();
    done_cnt = 0;
  endtask

  task automatic push_word(input logic [15:0] d, input int gap);
    q_data.push_back(d);
    q_gap.push_back(gap);
  endtask

  task automatic do_start(input logic [15:0] a, input logic [13:0] c, input logic [1:0] w);
    @(negedge clk_bus);
    start = 1'b1; base_addr = a; count = c; wtbt = w;
    @(negedge clk_bus);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int n, input int budget);
    int k = 0;
    while (done_cnt < n && k < budget) begin
      @(negedge clk_bus);
      k++;
    end
    check(tag, done_cnt >= n, 1);
  endtask

  task automatic wait_writes(input string tag, input int n, input int budget);
    int k = 0;
    while (wr_addr.size() < n && k < budget) begin
      @(negedge clk_bus);
      k++;
    end
    check(tag, wr_addr.size() >= n, 1);
  endtask

  task automatic wait_stb(input string tag, input int budget);
    int k = 0;
    while (!bus_stb && k < budget) begin
      @(negedge clk_bus);
      k++;
    end
    check(tag, bus_stb, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_bus);
  endtask

  logic [15:0] exp_addr[3];
  logic [15:0] exp_data[3];
  logic        activity;
  int          stb_len;

  initial begin
    // Reset values
    idle(3);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_sync", bus_sync, 0);
    check("rst_stb", bus_stb, 0);
    check("rst_ready", s_ready, 0);
    check("rst_addr", bus_addr, 16'h0);
    check("rst_dout", bus_dout, 16'h0);
    reset = 1'b0;
    idle(2);

    // Three words, immediate ack, s_valid held high
    clear_log();
    exp_addr = '{16'h4000, 16'h4002, 16'h4004};
    exp_data = '{16'h1111, 16'h2222, 16'h3333};
    for (int i = 0; i < 3; i++) push_word(exp_data[i], 0);
    do_start(16'o040000, 14'd3, 2'b11);
    check("t1_busy", busy, 1);
    wait_done("t1_wait_done", 1, 60);
    idle(5);
    check("t1_nwr", wr_addr.size(), 3);
    for (int i = 0; i < 3 && i < wr_addr.size(); i++) begin
      check($sformatf("t1_addr%0d", i), wr_addr[i], exp_addr[i]);
      check($sformatf("t1_data%0d", i), wr_data[i], exp_data[i]);
      check($sformatf("t1_wtbt%0d", i), wr_wtbt[i], 2'b11);
    end
    if (wr_cyc.size() == 3) begin
      check("t1_rate", wr_cyc[1] - wr_cyc[0], 4);
      check("t1_done_lat", done_cyc - wr_cyc[2], 2);
    end
    check("t1_done_once", done_cnt, 1);
    check("t1_busy_after", busy, 0);

    // Stream stall between words
    clear_log();
    push_word(16'hA5A5, 0);
    push_word(16'h5A5A, 10);
    do_start(16'h2000, 14'd2, 2'b11);
    wait_writes("t2_wait_w0", 1, 30);
    idle(3);
    activity = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_bus);
      activity = activity | bus_sync | bus_stb;
    end
    check("t2_quiet", activity, 0);
    check("t2_ready", s_ready, 1);
    wait_done("t2_wait_done", 1, 60);
    idle(4);
    check("t2_nwr", wr_addr.size(), 2);
    if (wr_addr.size() == 2) begin
      check("t2_addr1", wr_addr[1], 16'h2002);
      check("t2_data1", wr_data[1], 16'h5A5A);
    end

    // Address wrap
    clear_log();
    push_word(16'h0BEE, 0);
    push_word(16'h0CAF, 0);
    do_start(16'hFFFE, 14'd2, 2'b10);
    wait_done("t3_wait_done", 1, 40);
    idle(3);
    check("t3_nwr", wr_addr.size(), 2);
    if (wr_addr.size() == 2) begin
      check("t3_addr0", wr_addr[0], 16'hFFFE);
      check("t3_addr1", wr_addr[1], 16'h0000);
    end
    check("t3_error", error, 0);

    // Odd base address, single word
    clear_log();
    push_word(16'h00FF, 0);
    do_start(16'o177665, 14'd1, 2'b01);
    wait_done("t4_wait_done", 1, 30);
    idle(3);
    check("t4_nwr", wr_addr.size(), 1);
    if (wr_addr.size() == 1) begin
      check("t4_addr", wr_addr[0], 16'o177664);
      check("t4_wtbt", wr_wtbt[0], 2'b01);
      check("t4_data", wr_data[0], 16'h00FF);
    end

    // Zero count: done only
    clear_log();
    do_start(16'h1234, 14'd0, 2'b11);
    check("t5_done", done, 1);
    check("t5_busy", busy, 0);
    check("t5_sync", bus_sync, 0);
    @(negedge clk_bus);
    check("t5_done_off", done, 0);
    idle(3);
    check("t5_nwr", wr_addr.size(), 0);
    check("t5_done_cnt", done_cnt, 1);

    // Reset while strobe is stuck
    clear_log();
    ack_en = 1'b0;
    push_word(16'h7777, 0);
    do_start(16'h3000, 14'd2, 2'b11);
    wait_stb("t6_wait_stb", 20);
    idle(3);
    reset = 1'b1;
    @(negedge clk_bus);
    check("t6_stb", bus_stb, 0);
    check("t6_sync", bus_sync, 0);
    check("t6_busy", busy, 0);
    check("t6_addr", bus_addr, 16'h0);
    check("t6_dout", bus_dout, 16'h0);
    check("t6_ready", s_ready, 0);
    reset = 1'b0;
    ack_en = 1'b1;
    idle(3);
    check("t6_no_done", done_cnt, 0);
    push_word(16'hABCD, 0);
    do_start(16'h1000, 14'd1, 2'b11);
    wait_done("t6_wait_done", 1, 30);
    idle(2);
    check("t6_nwr", wr_addr.size(), 1);
    if (wr_addr.size() == 1) begin
      check("t6_addr_after", wr_addr[0], 16'h1000);
      check("t6_data_after", wr_data[0], 16'hABCD);
    end

`ifdef BUS_TIMEOUT_EN
    // Strobe timeout
    clear_log();
    ack_en = 1'b0;
    push_word(16'h4444, 0);
    do_start(16'h5000, 14'd1, 2'b11);
    wait_stb("t7_wait_stb", 20);
    stb_len = 0;
    while (bus_stb && stb_len < 50) begin
      stb_len++;
      @(negedge clk_bus);
    end
    check("t7_stb_len", stb_len, 8);
    check("t7_error", error, 1);
    check("t7_sync", bus_sync, 0);
    check("t7_busy", busy, 0);
    idle(3);
    check("t7_no_done", done_cnt, 0);
    ack_en = 1'b1;
    push_word(16'h4545, 0);
    do_start(16'h5000, 14'd1, 2'b11);
    check("t7_error_clr", error, 0);
    wait_done("t7_wait_done", 1, 30);
`endif

    idle(2);
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
